// File: rtl/combine_rr_pkg.sv
// Shared types for the round-robin memory combiner: FSM state and operation encodings.
// Optional build macro used by the combiner: COMBINE_RR_RANGE_CHECK_EN.
package combine_rr_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    typedef enum logic {
        OpRd = 1'b0,
        OpWr = 1'b1
    } op_e;

    // Width of a port index; a single port still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/combine_rr_if.sv
// Requester and memory-side bundle of the combiner.
// slave: the combiner's view. master: the clients plus memory model driving it.
interface combine_rr_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned WORD_WIDTH = 64,
    parameter int unsigned PORTS      = 2
);
    logic [PORTS*ADDR_WIDTH-1:0] addr;
    logic [PORTS*WORD_WIDTH-1:0] din;
    logic [PORTS*WORD_WIDTH-1:0] dout;
    logic [PORTS-1:0]            re;
    logic [PORTS-1:0]            we;
    logic [PORTS-1:0]            ready;
    logic [ADDR_WIDTH-1:0]       maddr;
    logic [WORD_WIDTH-1:0]       mout;
    logic [WORD_WIDTH-1:0]       min;
    logic                        mre;
    logic                        mwe;
    logic                        mready;

    modport slave (
        input  addr, din, re, we, min, mready,
        output dout, ready, maddr, mout, mre, mwe
    );

    modport master (
        output addr, din, re, we, min, mready,
        input  dout, ready, maddr, mout, mre, mwe
    );
endinterface

// File: rtl/combine_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last granted port (circular).
// The pointer moves to the granted port only when advance is high and a grant exists.
module combine_rr_arbiter import combine_rr_pkg::*; #(
    parameter int unsigned N = 2,
    localparam int unsigned IdxW = idx_width(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_i,
    input  logic            advance_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            any_o
);
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic            found;
    int              cand;

    // Circular search starting one past the pointer.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= int'(N); k++) begin
            cand = (int'(ptr_q) + k) % int'(N);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                idx_o       = IdxW'(cand);
                gnt_o[cand] = 1'b1;
            end
        end
        any_o = found;
        ptr_d = (advance_i && found) ? idx_o : ptr_q;
    end

    // Pointer starts at the last port so port 0 wins the first contested grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= IdxW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/combine_rr.sv
// N-port round-robin combiner onto one memory port, one transaction in flight.
// Port i is relocated to addr + i*OFFSET. Optional macro COMBINE_RR_RANGE_CHECK_EN adds
// a sticky err output and completes out-of-window requests locally without touching memory.
module combine_rr import combine_rr_pkg::*; #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned WORD_WIDTH = 64,
    parameter int unsigned PORTS      = 2,
    parameter int unsigned OFFSET     = 128
) (
    input  logic          clk,
    input  logic          rst,
    combine_rr_if.slave   bus
`ifdef COMBINE_RR_RANGE_CHECK_EN
    ,
    output logic          err
`endif
);
    localparam int unsigned IdxW = idx_width(PORTS);

    logic [PORTS-1:0]            req, arb_gnt;
    logic [IdxW-1:0]             arb_idx;
    logic                        arb_any, advance;
    logic [ADDR_WIDTH-1:0]       addr_g, reloc;
    logic [WORD_WIDTH-1:0]       din_g;

    state_e                      state_q, state_d;
    logic [PORTS-1:0]            gnt_q, gnt_d;
    logic [IdxW-1:0]             gidx_q, gidx_d;
    op_e                         op_q, op_d;
    logic [ADDR_WIDTH-1:0]       maddr_q, maddr_d;
    logic [WORD_WIDTH-1:0]       mout_q, mout_d;
    logic                        mre_q, mre_d, mwe_q, mwe_d;
    logic [PORTS-1:0]            ready_q, ready_d;
    logic [PORTS*WORD_WIDTH-1:0] dout_q, dout_d;
`ifdef COMBINE_RR_RANGE_CHECK_EN
    logic                        err_q, err_d;
`endif

    assign req     = bus.re | bus.we;
    assign advance = (state_q == StIdle);
    assign addr_g  = bus.addr[int'(arb_idx)*int'(ADDR_WIDTH) +: ADDR_WIDTH];
    assign din_g   = bus.din[int'(arb_idx)*int'(WORD_WIDTH) +: WORD_WIDTH];
    // Base of the granted window; wraps modulo 2^ADDR_WIDTH.
    assign reloc   = ADDR_WIDTH'(arb_idx) * ADDR_WIDTH'(OFFSET);

    combine_rr_arbiter #(
        .N (PORTS)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req),
        .advance_i (advance),
        .gnt_o     (arb_gnt),
        .idx_o     (arb_idx),
        .any_o     (arb_any)
    );

    // Next-state and registered-output logic for IDLE -> BUSY -> DONE.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        op_d    = op_q;
        maddr_d = maddr_q;
        mout_d  = mout_q;
        mre_d   = mre_q;
        mwe_d   = mwe_q;
        ready_d = '0;
        dout_d  = dout_q;
`ifdef COMBINE_RR_RANGE_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (arb_any) begin
                    gnt_d  = arb_gnt;
                    gidx_d = arb_idx;
                    // A simultaneous read and write is treated as a write.
                    op_d   = bus.we[arb_idx] ? OpWr : OpRd;
`ifdef COMBINE_RR_RANGE_CHECK_EN
                    if (addr_g >= ADDR_WIDTH'(OFFSET)) begin
                        state_d = StDone;
                        ready_d = arb_gnt;
                        dout_d[int'(arb_idx)*int'(WORD_WIDTH) +: WORD_WIDTH] = '0;
                        err_d   = 1'b1;
                    end else begin
`else
                    begin
`endif
                        state_d = StBusy;
                        maddr_d = addr_g + reloc;
                        mout_d  = din_g;
                        mre_d   = ~bus.we[arb_idx];
                        mwe_d   = bus.we[arb_idx];
                    end
                end
            end
            StBusy: begin
                if (bus.mready) begin
                    mre_d   = 1'b0;
                    mwe_d   = 1'b0;
                    ready_d = gnt_q;
                    state_d = StDone;
                    if (op_q == OpRd) begin
                        dout_d[int'(gidx_q)*int'(WORD_WIDTH) +: WORD_WIDTH] = bus.min;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            gidx_q  <= '0;
            op_q    <= OpRd;
            maddr_q <= '0;
            mout_q  <= '0;
            mre_q   <= 1'b0;
            mwe_q   <= 1'b0;
            ready_q <= '0;
            dout_q  <= '0;
`ifdef COMBINE_RR_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            op_q    <= op_d;
            maddr_q <= maddr_d;
            mout_q  <= mout_d;
            mre_q   <= mre_d;
            mwe_q   <= mwe_d;
            ready_q <= ready_d;
            dout_q  <= dout_d;
`ifdef COMBINE_RR_RANGE_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign bus.maddr = maddr_q;
    assign bus.mout  = mout_q;
    assign bus.mre   = mre_q;
    assign bus.mwe   = mwe_q;
    assign bus.ready = ready_q;
    assign bus.dout  = dout_q;
`ifdef COMBINE_RR_RANGE_CHECK_EN
    assign err       = err_q;
`endif
endmodule

// File: tb/tb_combine_rr.sv
// Self-checking bench for combine_rr (2 ports, 128-word windows).
// Honours COMBINE_RR_RANGE_CHECK_EN when defined for the build.
module tb_combine_rr;
    localparam int unsigned AW  = 64;
    localparam int unsigned WW  = 64;
    localparam int unsigned NP  = 2;
    localparam int unsigned OFF = 128;
    localparam int          NTX = 25;

    logic clk = 1'b0;
    logic rst = 1'b1;

    combine_rr_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .PORTS(NP)) bus ();
`ifdef COMBINE_RR_RANGE_CHECK_EN
    logic err;
`endif

    combine_rr #(
        .ADDR_WIDTH (AW),
        .WORD_WIDTH (WW),
        .PORTS      (NP),
        .OFFSET     (OFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef COMBINE_RR_RANGE_CHECK_EN
        ,
        .err (err)
`endif
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int failures  = 0;

    // Memory responder state.
    logic [63:0] mem [logic [63:0]];
    int          mem_delay  = 0;
    bit          rand_delay = 1'b0;
    bit          active     = 1'b0;
    int          cnt        = 0;
    int          cur_delay  = 0;
    logic [63:0] last_maddr = '0;
    logic [63:0] last_mout  = '0;
    logic        last_wr    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int p, input logic r, input logic w,
                           input logic [63:0] a, input logic [63:0] d);
        bus.re[p]             = r;
        bus.we[p]             = w;
        bus.addr[p*AW +: AW]  = a;
        bus.din[p*WW +: WW]   = d;
    endtask

    function automatic logic [63:0] dout_of(input int p);
        return bus.dout[p*WW +: WW];
    endfunction

    // Memory model: answers a held strobe after cur_delay extra cycles with a one-cycle mready.
    initial begin
        bus.mready = 1'b0;
        bus.min    = '0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.mready || rst || !(bus.mre || bus.mwe)) begin
                bus.mready = 1'b0;
                active     = 1'b0;
            end else begin
                if (!active) begin
                    active    = 1'b1;
                    cnt       = 0;
                    cur_delay = rand_delay ? int'($urandom_range(0, 3)) : mem_delay;
                end else begin
                    cnt++;
                end
                if (cnt >= cur_delay) begin
                    bus.mready = 1'b1;
                    last_maddr = bus.maddr;
                    last_mout  = bus.mout;
                    last_wr    = bus.mwe;
                    if (bus.mwe) mem[bus.maddr] = bus.mout;
                    else bus.min = mem.exists(bus.maddr) ? mem[bus.maddr] : 64'h0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One isolated transaction from an idle DUT; latency counted in edges from the sampling edge.
    task automatic run_single(input string tag, input int p, input logic r, input logic w,
                              input logic [63:0] a, input logic [63:0] d, input int dly,
                              input logic [63:0] exp_maddr, input logic exp_wr,
                              input logic [63:0] exp_dout);
        int edges;
        bit seen;
        bit got;
        edges     = 0;
        seen      = 1'b0;
        got       = 1'b0;
        mem_delay = dly;
        set_req(p, r, w, a, d);
        while (!got && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (!seen && (bus.mre || bus.mwe)) begin
                seen = 1'b1;
                check({tag, " strobe cycle"}, 64'(edges), 64'd1);
                check({tag, " maddr"}, bus.maddr, exp_maddr);
                check({tag, " mre"}, 64'(bus.mre), 64'(!exp_wr));
                check({tag, " mwe"}, 64'(bus.mwe), 64'(exp_wr));
                if (exp_wr) check({tag, " mout"}, bus.mout, d);
            end
            if (bus.ready != '0) begin
                got = 1'b1;
                check({tag, " ready port"}, 64'(bus.ready), 64'(1) << p);
                check({tag, " latency"}, 64'(edges), 64'(dly + 2));
                check({tag, " strobes dropped"}, 64'(bus.mre | bus.mwe), 64'd0);
                if (!exp_wr) check({tag, " dout"}, dout_of(p), exp_dout);
            end
        end
        check({tag, " completed"}, 64'(got), 64'd1);
        set_req(p, 1'b0, 1'b0, a, d);
        @(posedge clk);
        #1;
        check({tag, " ready single pulse"}, 64'(bus.ready), 64'd0);
    endtask

    typedef struct {
        int          port;
        logic        re;
        logic        we;
        logic [63:0] addr;
        logic [63:0] din;
        int          dly;
        logic [63:0] exp_maddr;
        logic        exp_wr;
        logic [63:0] exp_dout;
    } vec_t;

    vec_t vecs [6];

    // Random-phase requester and reference-model state.
    bit          req_on    [NP];
    int          remaining [NP];
    int          gap       [NP];
    int          age       [NP];
    int          waits     [NP];
    logic [63:0] cur_addr  [NP];
    logic [63:0] cur_din   [NP];
    logic        cur_wr    [NP];
    logic [63:0] exp_dout  [NP];
    logic [63:0] ref_win   [NP][OFF];

    initial begin
        int               k;
        int               cyc;
        int               p;
        int               done_cnt;
        bit               got;
        bit               strobe;
        bit               abort;
        logic [NP-1:0]    prev_rdy;
        logic [NP-1:0]    reassert;
        int               edges;
        int               sel;

        bus.addr = '0;
        bus.din  = '0;
        bus.re   = '0;
        bus.we   = '0;
        mem[64'd133] = 64'hAB;
        mem[64'd255] = 64'hCAFE;
        mem[64'd130] = 64'h99;
        mem[64'd200] = 64'h77;

        vecs[0] = '{1, 1'b1, 1'b0, 64'd5,   64'h0,    2, 64'd133, 1'b0, 64'hAB};
        vecs[1] = '{0, 1'b0, 1'b1, 64'd7,   64'h55,   1, 64'd7,   1'b1, 64'h0};
        vecs[2] = '{0, 1'b1, 1'b0, 64'd7,   64'h0,    0, 64'd7,   1'b0, 64'h55};
        vecs[3] = '{1, 1'b1, 1'b1, 64'd9,   64'h1234, 0, 64'd137, 1'b1, 64'h0};
        vecs[4] = '{1, 1'b1, 1'b0, 64'd9,   64'h0,    3, 64'd137, 1'b0, 64'h1234};
        vecs[5] = '{1, 1'b1, 1'b0, 64'd127, 64'h0,    1, 64'd255, 1'b0, 64'hCAFE};

        // Reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset mre", 64'(bus.mre), 64'd0);
        check("reset mwe", 64'(bus.mwe), 64'd0);
        check("reset ready", 64'(bus.ready), 64'd0);
        check("reset maddr", bus.maddr, 64'd0);
        check("reset mout", bus.mout, 64'd0);
        check("reset dout0", dout_of(0), 64'd0);
        check("reset dout1", dout_of(1), 64'd0);
`ifdef COMBINE_RR_RANGE_CHECK_EN
        check("reset err", 64'(err), 64'd0);
`endif
        rst = 1'b0;

        // Contention: both ports re-request one cycle after each completion.
        mem_delay = 0;
        set_req(0, 1'b1, 1'b0, 64'd0, 64'd0);
        set_req(1, 1'b1, 1'b0, 64'd1, 64'd0);
        k        = 0;
        cyc      = 0;
        prev_rdy = '0;
        reassert = '0;
        while (k < 4 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            bus.re   = bus.re | reassert;
            reassert = '0;
            if (prev_rdy != '0) check("contention single pulse", 64'(bus.ready), 64'd0);
            if (bus.ready != '0) begin
                check($sformatf("contention grant %0d", k), 64'(bus.ready), 64'(1) << (k % 2));
                p            = bus.ready[1] ? 1 : 0;
                bus.re[p]    = 1'b0;
                reassert[p]  = 1'b1;
                k++;
            end
            prev_rdy = bus.ready;
        end
        check("contention transactions", 64'(k), 64'd4);
        bus.re = '0;
        repeat (3) @(posedge clk);
        #1;

        // Table of isolated single transactions.
        for (int i = 0; i < 6; i++) begin
            run_single($sformatf("vec%0d", i), vecs[i].port, vecs[i].re, vecs[i].we,
                       vecs[i].addr, vecs[i].din, vecs[i].dly, vecs[i].exp_maddr,
                       vecs[i].exp_wr, vecs[i].exp_dout);
        end

        // Reset while BUSY abandons the transaction.
        mem_delay = 20;
        set_req(0, 1'b1, 1'b0, 64'd3, 64'd0);
        strobe = 1'b0;
        for (int i = 0; i < 10 && !strobe; i++) begin
            @(posedge clk);
            #1;
            strobe = bus.mre;
        end
        check("abort strobe before rst", 64'(strobe), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort mre", 64'(bus.mre), 64'd0);
        check("abort mwe", 64'(bus.mwe), 64'd0);
        check("abort ready", 64'(bus.ready), 64'd0);
        rst = 1'b0;
        bus.re = '0;
        got = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.ready != '0 || bus.mre || bus.mwe) got = 1'b1;
        end
        check("abort no late activity", 64'(got), 64'd0);
        run_single("after abort", 1, 1'b1, 1'b0, 64'd2, 64'd0, 1, 64'd130, 1'b0, 64'h99);

        // Out-of-window address on port 0; first make dout0 non-zero.
        run_single("pre range", 0, 1'b1, 1'b0, 64'd7, 64'd0, 0, 64'd7, 1'b0, 64'h55);
`ifdef COMBINE_RR_RANGE_CHECK_EN
        set_req(0, 1'b1, 1'b0, 64'd200, 64'd0);
        got    = 1'b0;
        strobe = 1'b0;
        edges  = 0;
        while (!got && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.mre || bus.mwe) strobe = 1'b1;
            if (bus.ready != '0) begin
                got = 1'b1;
                check("range ready", 64'(bus.ready), 64'd1);
                check("range latency", 64'(edges), 64'd1);
                check("range dout0", dout_of(0), 64'd0);
                check("range err", 64'(err), 64'd1);
            end
        end
        check("range completed", 64'(got), 64'd1);
        check("range no strobe", 64'(strobe), 64'd0);
        bus.re = '0;
        repeat (4) @(posedge clk);
        #1;
        check("range err sticky", 64'(err), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("range err cleared", 64'(err), 64'd0);
        rst = 1'b0;
`else
        run_single("alias 200", 0, 1'b1, 1'b0, 64'd200, 64'd0, 0, 64'd200, 1'b0, 64'h77);
`endif

        // Randomized traffic against a per-port window model.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem.delete();
        rand_delay = 1'b1;
        for (int i = 0; i < int'(NP); i++) begin
            req_on[i]    = 1'b0;
            remaining[i] = NTX;
            gap[i]       = int'($urandom_range(0, 2));
            age[i]       = 0;
            waits[i]     = 0;
            exp_dout[i]  = '0;
            for (int j = 0; j < int'(OFF); j++) ref_win[i][j] = '0;
        end
        done_cnt = 0;
        cyc      = 0;
        abort    = 1'b0;
        while (!abort && cyc < 8000 && done_cnt < NTX * int'(NP)) begin
            for (int i = 0; i < int'(NP); i++) begin
                if (!req_on[i]) begin
                    if (gap[i] > 0) gap[i]--;
                    if (gap[i] == 0 && remaining[i] > 0) begin
                        sel         = int'($urandom_range(0, 2));
                        cur_addr[i] = 64'($urandom_range(0, OFF - 1));
                        cur_din[i]  = {$urandom, $urandom};
                        cur_wr[i]   = (sel != 0);
                        set_req(i, sel != 1, sel != 0, cur_addr[i], cur_din[i]);
                        req_on[i] = 1'b1;
                        waits[i]  = 0;
                        age[i]    = 0;
                    end
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            check("rand ready onehot", 64'($onehot0(bus.ready)), 64'd1);
            for (int i = 0; i < int'(NP); i++) begin
                if (bus.ready[i]) begin
                    check($sformatf("rand p%0d ready has request", i), 64'(req_on[i]), 64'd1);
                    if (req_on[i]) begin
                        check($sformatf("rand p%0d op", i), 64'(last_wr), 64'(cur_wr[i]));
                        check($sformatf("rand p%0d maddr", i), last_maddr,
                              cur_addr[i] + 64'(i) * 64'(OFF));
                        // One transaction may already be in flight when the request arrives.
                        check($sformatf("rand p%0d fairness", i), 64'(waits[i] <= int'(NP)),
                              64'd1);
                        if (cur_wr[i]) begin
                            check($sformatf("rand p%0d mout", i), last_mout, cur_din[i]);
                            ref_win[i][cur_addr[i][6:0]] = cur_din[i];
                        end else begin
                            exp_dout[i] = ref_win[i][cur_addr[i][6:0]];
                        end
                        check($sformatf("rand p%0d dout", i), dout_of(i), exp_dout[i]);
                        for (int j = 0; j < int'(NP); j++) begin
                            if (j != i && req_on[j]) waits[j]++;
                        end
                        req_on[i] = 1'b0;
                        set_req(i, 1'b0, 1'b0, cur_addr[i], cur_din[i]);
                        gap[i] = int'($urandom_range(2, 4));
                        remaining[i]--;
                        done_cnt++;
                    end
                end else begin
                    check($sformatf("rand p%0d dout hold", i), dout_of(i), exp_dout[i]);
                end
            end
            for (int i = 0; i < int'(NP); i++) begin
                if (req_on[i]) begin
                    age[i]++;
                    if (age[i] > 300) begin
                        check($sformatf("rand p%0d request age", i), 64'(age[i]), 64'd0);
                        abort = 1'b1;
                    end
                end
            end
        end
        check("rand transactions done", 64'(done_cnt), 64'(NTX * int'(NP)));

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
